rf_multiport: RTL and testbench

- Next-generation integer register file for the NPC core. Parametrised in width, depth, read-port count and write-port count.
- Adds asynchronous clear, write-to-read bypass, and a per-register pending scoreboard so a pipelined/superscalar front-end can detect RAW/WAW hazards.
- Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 75 +++++++
 rtl/rf_multiport.sv | 116 +++++++++++
 tb/tb_rf_multiport.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, types and constants for the multiport register file.
package rf_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ZERO_REG   = 0;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits for RAW/WAW hazard detection.
// A reservation from issue sets the bit; any writeback to the register clears it.
// When both happen in the same cycle the new reservation wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1,
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DEPTH-1:0]             i_wr_hit,
    input  logic                         i_iss_valid,
    input  logic [ADDR_WIDTH-1:0]        i_iss_rd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_raddr,
    output logic [NUM_RD-1:0]            o_rbusy,
    output logic                         o_iss_ready,
    output logic [DEPTH-1:0]             o_pending
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_d;
    logic [DEPTH-1:0] w_set;
    logic             w_iss_ready;

    // WAW check: a pending destination may only be re-reserved in the cycle it is written back.
    always_comb begin
        w_iss_ready = !r_pending[i_iss_rd] || i_wr_hit[i_iss_rd];
    end

    // Decode the accepted reservation into a one-hot set vector (x0 is never reserved).
    always_comb begin
        w_set = '0;
        if (i_iss_valid && w_iss_ready && (i_iss_rd != ADDR_WIDTH'(RF_ZERO_REG))) begin
            w_set[i_iss_rd] = 1'b1;
        end
    end

    // Next pending state: set has priority over clear.
    always_comb begin
        w_pending_d = r_pending;
        for (int n = 0; n < int'(DEPTH); n++) begin
            if (w_set[n]) begin
                w_pending_d[n] = 1'b1;
            end else if (i_wr_hit[n]) begin
                w_pending_d[n] = 1'b0;
            end
        end
        w_pending_d[RF_ZERO_REG] = 1'b0;
    end

    // Pending register; reset discards every outstanding reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    // Per read port busy: pending and not satisfied by a forwarded write this cycle.
    always_comb begin
        o_rbusy = '0;
        for (int j = 0; j < int'(NUM_RD); j++) begin
            o_rbusy[j] = r_pending[i_raddr[j*ADDR_WIDTH +: ADDR_WIDTH]]
                && !((BYPASS != 0) && i_wr_hit[i_raddr[j*ADDR_WIDTH +: ADDR_WIDTH]]);
        end
    end

    assign o_iss_ready = w_iss_ready;
    assign o_pending   = r_pending;

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: multiport integer register file with write-to-read bypass and
// a pending scoreboard. x0 reads zero and ignores writes.
// Optional macro RF_DPI_DUMP_EN adds an info_r input that dumps the array and
// pending vector on each posedge where info_r is high.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef RF_DPI_DUMP_EN
    input  logic                         info_r,
`endif
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    output logic                         iss_ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_rf      [DEPTH];
    logic [DATA_WIDTH-1:0] w_wr_data [DEPTH];
    logic [DEPTH-1:0]      w_wr_hit;
    logic [DEPTH-1:0]      w_pending;
    logic [ADDR_WIDTH-1:0] w_ra      [NUM_RD];

    // Resolve write ports per register; later (higher-index) ports override earlier ones.
    always_comb begin
        w_wr_hit = '0;
        for (int n = 0; n < int'(DEPTH); n++) begin
            w_wr_data[n] = '0;
        end
        for (int n = 1; n < int'(DEPTH); n++) begin
            for (int k = 0; k < int'(NUM_WR); k++) begin
                if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(n))) begin
                    w_wr_hit[n]  = 1'b1;
                    w_wr_data[n] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Register array; x0 is held at zero because it never gets a write hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < int'(DEPTH); n++) begin
                r_rf[n] <= '0;
            end
        end else begin
            for (int n = 0; n < int'(DEPTH); n++) begin
                if (w_wr_hit[n]) begin
                    r_rf[n] <= w_wr_data[n];
                end
            end
        end
    end

    // Read muxes with optional bypass; forced to zero while reset is asserted so
    // write data presented during reset cannot leak through the bypass.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < int'(NUM_RD); j++) begin
            w_ra[j] = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            if (!rst_n || (w_ra[j] == ADDR_WIDTH'(RF_ZERO_REG))) begin
                rdata[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && w_wr_hit[w_ra[j]]) begin
                rdata[j*DATA_WIDTH +: DATA_WIDTH] = w_wr_data[w_ra[j]];
            end else begin
                rdata[j*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_ra[j]];
            end
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_hit    (w_wr_hit),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_raddr     (raddr),
        .o_rbusy     (rbusy),
        .o_iss_ready (iss_ready),
        .o_pending   (w_pending)
    );

`ifdef RF_DPI_DUMP_EN
    // Debug dump of architectural state on request.
    always @(posedge clk) begin
        if (info_r) begin
            for (int n = 0; n < int'(DEPTH); n++) begin
                $display("x%0d = %h", n, r_rf[n]);
            end
            $display("pending = %b", w_pending);
        end
    end
`else
    logic w_unused_pending;
    assign w_unused_pending = ^w_pending;
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed scoreboard bench. Two DUTs share stimulus, one with
// bypass and one without; expectations are queued by the driver and checked by
// a monitor on the falling clock edge.
module tb_rf_multiport;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [1:0]    wen;
    logic [2*AW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [2*DW-1:0] rdata_b, rdata_n;
    logic [1:0]    rbusy_b, rbusy_n;
    logic          ready_b, ready_n;

    rf_multiport #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_RD (2), .NUM_WR (2), .BYPASS (1)
    ) u_dut_byp (
        .clk (clk), .rst_n (rst_n), .wen (wen), .waddr (waddr), .wdata (wdata),
        .raddr (raddr), .rdata (rdata_b), .rbusy (rbusy_b),
        .iss_valid (iss_valid), .iss_rd (iss_rd), .iss_ready (ready_b)
    );

    rf_multiport #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_RD (2), .NUM_WR (2), .BYPASS (0)
    ) u_dut_nobyp (
        .clk (clk), .rst_n (rst_n), .wen (wen), .waddr (waddr), .wdata (wdata),
        .raddr (raddr), .rdata (rdata_n), .rbusy (rbusy_n),
        .iss_valid (iss_valid), .iss_rd (iss_rd), .iss_ready (ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kinds: 0 rdata, 1 rbusy, 2 iss_ready; dut: 0 bypass, 1 no bypass
    string       q_name [$];
    int          q_kind [$];
    int          q_dut  [$];
    int          q_port [$];
    logic [31:0] q_exp  [$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] get_act(int k, int d, int p);
        case (k)
            0:       return (d == 0) ? rdata_b[p*DW +: DW] : rdata_n[p*DW +: DW];
            1:       return {31'b0, (d == 0) ? rbusy_b[p] : rbusy_n[p]};
            default: return {31'b0, (d == 0) ? ready_b : ready_n};
        endcase
    endfunction

    string       m_name;
    int          m_kind, m_dut, m_port;
    logic [31:0] m_exp, m_act;

    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            m_name = q_name.pop_front();
            m_kind = q_kind.pop_front();
            m_dut  = q_dut.pop_front();
            m_port = q_port.pop_front();
            m_exp  = q_exp.pop_front();
            m_act  = get_act(m_kind, m_dut, m_port);
            n_vec++;
            if (m_act !== m_exp) begin
                n_bad++;
                $display("FAIL %s dut=%0d port=%0d got=%h want=%h",
                         m_name, m_dut, m_port, m_act, m_exp);
            end
        end
    end

    task automatic push(input string nm, input int k, input int d, input int p,
                        input logic [31:0] v);
        q_name.push_back(nm);
        q_kind.push_back(k);
        q_dut.push_back(d);
        q_port.push_back(p);
        q_exp.push_back(v);
    endtask

    // Expectation on both DUTs: vb for bypass build, vn for non-bypass build.
    task automatic exp2(input string nm, input int k, input int p,
                        input logic [31:0] vb, input logic [31:0] vn);
        push(nm, k, 0, p, vb);
        push(nm, k, 1, p, vn);
    endtask

    task automatic idle();
        wen       = '0;
        waddr     = '0;
        wdata     = '0;
        iss_valid = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[p]           = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        raddr  = '0;
        iss_rd = '0;
        idle();
        next_cycle();

        // In reset: write presented to x5 must not appear, even via bypass.
        set_wr(0, 5'd5, 32'hCAFE_0005);
        set_rd(0, 5'd5);
        set_rd(1, 5'd5);
        iss_rd = 5'd5;
        exp2("rst_rdata0", 0, 0, 32'h0, 32'h0);
        exp2("rst_rbusy0", 1, 0, 32'h0, 32'h0);
        exp2("rst_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        rst_n = 1'b1;
        idle();

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(31 - a));
            iss_rd = AW'(a);
            exp2("sweep_rdata0", 0, 0, 32'h0, 32'h0);
            exp2("sweep_rdata1", 0, 1, 32'h0, 32'h0);
            exp2("sweep_rbusy0", 1, 0, 32'h0, 32'h0);
            exp2("sweep_rbusy1", 1, 1, 32'h0, 32'h0);
            exp2("sweep_ready", 2, 0, 32'h1, 32'h1);
            next_cycle();
        end

        // Single write x5 on port0: bypass sees it now, no-bypass next cycle.
        idle();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5);
        exp2("wr_x5_same", 0, 0, 32'hDEAD_BEEF, 32'h0);
        next_cycle();
        idle();
        exp2("wr_x5_next", 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        next_cycle();

        // Collision on x7: port1 wins in array and bypass.
        set_wr(0, 5'd7, 32'h1111);
        set_wr(1, 5'd7, 32'h2222);
        set_rd(0, 5'd7);
        exp2("coll_x7_same", 0, 0, 32'h2222, 32'h0);
        next_cycle();
        idle();
        exp2("coll_x7_next", 0, 0, 32'h2222, 32'h2222);
        next_cycle();

        // Write to x0 is dropped, bypass included.
        set_wr(0, 5'd0, 32'hFFFF);
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        exp2("x0_same", 0, 0, 32'h0, 32'h0);
        next_cycle();
        idle();
        exp2("x0_next", 0, 1, 32'h0, 32'h0);
        next_cycle();

        // RAW hazard on x3.
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        exp2("raw_iss_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        idle();
        set_rd(0, 5'd3);
        exp2("raw_busy", 1, 0, 32'h1, 32'h1);
        exp2("raw_waw_block", 2, 0, 32'h0, 32'h0);
        next_cycle();
        set_wr(0, 5'd3, 32'h42);
        exp2("raw_wb_busy", 1, 0, 32'h0, 32'h1);
        exp2("raw_wb_data", 0, 0, 32'h42, 32'h0);
        next_cycle();
        idle();
        exp2("raw_after_busy", 1, 0, 32'h0, 32'h0);
        exp2("raw_after_data", 0, 0, 32'h42, 32'h42);
        next_cycle();

        // WAW hazard on x9, with issue in the writeback cycle.
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        exp2("waw_first_iss", 2, 0, 32'h1, 32'h1);
        next_cycle();
        idle();
        exp2("waw_blocked", 2, 0, 32'h0, 32'h0);
        next_cycle();
        set_wr(1, 5'd9, 32'h99);
        iss_valid = 1'b1;
        exp2("waw_wb_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        idle();
        set_rd(1, 5'd9);
        exp2("waw_still_busy", 1, 1, 32'h1, 32'h1);
        exp2("waw_data", 0, 1, 32'h99, 32'h99);
        exp2("waw_still_block", 2, 0, 32'h0, 32'h0);
        next_cycle();
        set_wr(0, 5'd9, 32'hAA);
        exp2("waw_clr_busy", 1, 1, 32'h0, 32'h1);
        next_cycle();
        idle();
        exp2("waw_clr_after", 1, 1, 32'h0, 32'h0);
        exp2("waw_clr_data", 0, 1, 32'hAA, 32'hAA);
        next_cycle();

        // Issue to x0 is accepted and reserves nothing.
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        exp2("iss_x0_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        idle();
        set_rd(0, 5'd0);
        exp2("iss_x0_busy", 1, 0, 32'h0, 32'h0);
        next_cycle();

        // Asynchronous reset with x3 pending and x4 = 0x55.
        set_wr(0, 5'd4, 32'h55);
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        exp2("ar_iss", 2, 0, 32'h1, 32'h1);
        next_cycle();
        idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd3);
        exp2("ar_pre_data", 0, 0, 32'h55, 32'h55);
        exp2("ar_pre_busy", 1, 1, 32'h1, 32'h1);
        exp2("ar_pre_block", 2, 0, 32'h0, 32'h0);
        next_cycle();
        rst_n = 1'b0;
        set_wr(1, 5'd4, 32'h77);
        exp2("ar_in_data", 0, 0, 32'h0, 32'h0);
        exp2("ar_in_busy", 1, 1, 32'h0, 32'h0);
        exp2("ar_in_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        rst_n = 1'b1;
        idle();
        exp2("ar_post_data", 0, 0, 32'h0, 32'h0);
        exp2("ar_post_busy", 1, 1, 32'h0, 32'h0);
        exp2("ar_post_ready", 2, 0, 32'h1, 32'h1);
        next_cycle();
        next_cycle();

        if (q_kind.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover=%0d want=0", q_kind.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
